// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider sequencer.
package div_ctrl_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DIV_RES_W       = 64;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_watchdog.sv
// Hang watchdog: cycle counter with synchronous clear/enable and terminal count.
module div_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Execute-stage sequencer for the multi-cycle divider: operand latch,
// start/annul handshake, F/D/E stall, one-cycle HI/LO presentation,
// flush handling and hang watchdog.
// Optional: DIV_ZERO_FAST_EN resolves a zero divisor in IDLE without
// starting the divider (hi = dividend, lo = all ones).
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic                 signed_i,
  input  logic [DATA_W-1:0]    op_a_i,
  input  logic [DATA_W-1:0]    op_b_i,
  input  logic                 flush_i,
  input  logic                 ready_i,
  input  logic [DIV_RES_W-1:0] result_i,
  output logic                 start_o,
  output logic                 annul_o,
  output logic [DATA_W-1:0]    div_a_o,
  output logic [DATA_W-1:0]    div_b_o,
  output logic                 div_signed_o,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  state_t            state, state_nxt;
  logic              accept;
  logic              cap;
  logic [DATA_W-1:0] cap_hi, cap_lo;
  logic              set_to;
  logic              wd_en;
  logic              wd_tc;

  div_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (wd_en),
    .tc (wd_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/stall decode; flush beats ready beats watchdog.
  always_comb begin
    state_nxt = state;
    start_o   = 1'b0;
    annul_o   = 1'b0;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    busy_o    = 1'b0;
    accept    = 1'b0;
    cap       = 1'b0;
    cap_hi    = '0;
    cap_lo    = '0;
    set_to    = 1'b0;
    wd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && !flush_i) begin
          stall_o = 1'b1;
          accept  = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (op_b_i == '0) begin
            state_nxt = DONE;
            cap       = 1'b1;
            cap_hi    = op_a_i;
            cap_lo    = DIV0_LO;
          end else begin
            state_nxt = BUSY;
          end
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        start_o = 1'b1;
        stall_o = 1'b1;
        busy_o  = 1'b1;
        wd_en   = 1'b1;
        if (flush_i) begin
          annul_o   = 1'b1;
          state_nxt = IDLE;
        end else if (ready_i) begin
          cap       = 1'b1;
          cap_hi    = result_i[DIV_RES_W-1:DATA_W];
          cap_lo    = result_i[DATA_W-1:0];
          state_nxt = DONE;
        end else if (wd_tc) begin
          cap       = 1'b1;
          set_to    = 1'b1;
          annul_o   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, result capture and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_a_o      <= '0;
      div_b_o      <= '0;
      div_signed_o <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
      timeout_o    <= 1'b0;
    end else begin
      if (accept) begin
        div_a_o      <= op_a_i;
        div_b_o      <= op_b_i;
        div_signed_o <= signed_i;
      end
      if (cap) begin
        hi_o <= cap_hi;
        lo_o <= cap_lo;
      end
      if (set_to) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl with a latency-programmable divider model.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, signed_i, flush_i;
  logic [31:0] op_a_i, op_b_i;
  logic        ready_i;
  logic [63:0] result_i;
  logic        start_o, annul_o, div_signed_o, stall_o, done_o, busy_o, timeout_o;
  logic [31:0] div_a_o, div_b_o, hi_o, lo_o;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_now  = 0;
  int   mcnt     = 0;
  int   model_lat = 34;
  logic model_en  = 1'b1;
  logic exp_to    = 1'b0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  div_seq_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .signed_i(signed_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .ready_i(ready_i), .result_i(result_i),
    .start_o(start_o), .annul_o(annul_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_signed_o(div_signed_o), .stall_o(stall_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural divider: {remainder, quotient}; zero divisor gives {a, all ones}.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model: ready pulses on the model_lat-th consecutive start cycle.
  always @(posedge clk) begin
    cyc_now <= cyc_now + 1;
    if (rst || !start_o) mcnt <= 0;
    else                 mcnt <= mcnt + 1;
  end
  assign ready_i  = model_en && start_o && (mcnt == model_lat - 1);
  assign result_i = div_model(div_a_o, div_b_o, div_signed_o);

  // Scoreboard monitor: one expected entry per done pulse; done never two cycles.
  always @(negedge clk) begin
    exp_t e;
    if (done_o) begin
      check("done_single", 64'(prev_done), 64'd0);
      check("sb_pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hi", 64'(hi_o), 64'(e.hi));
        check("lo", 64'(lo_o), 64'(e.lo));
        check("timeout_at_done", 64'(timeout_o), 64'(e.to));
      end
    end
    prev_done <= done_o;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({start_o, annul_o, stall_o, done_o, busy_o, timeout_o, div_signed_o}), 64'd0);
    check({tag, "_ops"}, {div_a_o, div_b_o}, 64'd0);
    check({tag, "_res"}, {hi_o, lo_o}, 64'd0);
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one divide with req held until done; called #1 after a rising edge.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic eto,
                        input int exp_stall, input int exp_start, input int exp_annul,
                        output int done_at);
    int   stall_n = 0, start_n = 0, annul_n = 0, done_cyc = -1;
    logic frz_bad = 1'b0;
    if (eto) exp_to = 1'b1;
    sb.push_back('{hi: ehi, lo: elo, to: exp_to});
    req_i = 1'b1; signed_i = sgn; op_a_i = a; op_b_i = b; flush_i = 1'b0;
    done_at = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (stall_o) stall_n++;
      if (start_o) start_n++;
      if (annul_o) annul_n++;
      if (busy_o && (div_a_o !== a || div_b_o !== b || div_signed_o !== sgn)) frz_bad = 1'b1;
      if (done_o) begin
        done_cyc = c;
        done_at  = cyc_now;
        break;
      end
      @(posedge clk); #1;
      op_a_i = $urandom; op_b_i = $urandom; signed_i = ~sgn;
    end
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("done_latency", 64'(done_cyc), 64'(exp_stall));
    check("stall_cycles", 64'(stall_n), 64'(exp_stall));
    check("start_cycles", 64'(start_n), 64'(exp_start));
    check("annul_pulses", 64'(annul_n), 64'(exp_annul));
    check("ops_frozen", 64'(frz_bad), 64'd0);
    @(posedge clk); #1;
  endtask

  int d0, d1;

  initial begin
    rst = 1'b1; req_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
    op_a_i = '0; op_b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Unsigned 100/7, divider latency 34.
    model_lat = 34; model_en = 1'b1;
    do_div(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 35, 34, 0, d0);
    idle(2);

    // Signed -7/2.
    model_lat = 10;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 11, 10, 0, d0);
    idle(1);

    // Flush ignored in IDLE, then flush on BUSY cycle 5.
    req_i = 1'b1; flush_i = 1'b1; op_a_i = 32'd50; op_b_i = 32'd5; signed_i = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_busy_cycle5", 64'({busy_o, annul_o}), 64'b11);
    @(posedge clk); #1;
    flush_i = 1'b0; req_i = 1'b0;
    @(negedge clk);
    check("after_flush", 64'({annul_o, stall_o, busy_o, done_o, start_o}), 64'd0);
    @(posedge clk); #1;
    check("flush_sb_empty", 64'(sb.size()), 64'd0);
    do_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0, 11, 10, 0, d0);
    idle(1);

    // Back-to-back 20/3 then 21/4 with no gap cycle.
    model_lat = 5;
    do_div(32'd20, 32'd3, 1'b0, 32'd2, 32'd6, 1'b0, 6, 5, 0, d0);
    do_div(32'd21, 32'd4, 1'b0, 32'd1, 32'd5, 1'b0, 6, 5, 0, d1);
    check("b2b_gap", 64'(d1 - d0), 64'd7);
    idle(1);

    // Watchdog: divider never answers.
    model_en = 1'b0;
    do_div(32'd77, 32'd5, 1'b0, 32'd0, 32'd0, 1'b1, 65, 64, 1, d0);
    idle(1);
    model_en = 1'b1;
    do_div(32'd5, 32'd2, 1'b0, 32'd1, 32'd2, 1'b0, 6, 5, 0, d0);
    idle(2);
    check("timeout_sticky", 64'(timeout_o), 64'd1);

    // Reset on BUSY cycle 10 abandons without annul and clears everything.
    req_i = 1'b1; op_a_i = 32'd1000; op_b_i = 32'd3; signed_i = 1'b1;
    model_lat = 30;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; req_i = 1'b0;
    @(negedge clk);
    check("rst_cycle_busy_no_annul", 64'({busy_o, annul_o}), 64'b10);
    @(posedge clk); #1;
    rst = 1'b0; exp_to = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid_busy");
    @(posedge clk); #1;

    // Zero divisor.
    model_lat = 4;
`ifdef DIV_ZERO_FAST_EN
    do_div(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 1, 0, 0, d0);
`else
    do_div(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFF_FFFF, 1'b0, 5, 4, 0, d0);
`endif
    idle(2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
